// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: freeze/bubble/flush control for a 5-stage pipeline; STALL_PERF_CNT_EN enables the stall counter
module pipeline_stall_controller #(
  parameter int MAX_WAIT = 32,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             freeze_back,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          timeout_q, timeout_d;
  logic          miss;
  // Memory miss dominates; once waiting, only mem_ready releases the pipeline
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    timeout_d    = timeout_q;
    freeze_pc    = 1'b0;
    freeze_if_id = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    freeze_back  = 1'b0;
    miss         = state_q == MEM_WAIT ? !mem_ready : mem_req && !mem_ready;
    if (rst && miss) begin
      freeze_pc    = 1'b1;
      freeze_if_id = 1'b1;
      freeze_back  = 1'b1;
      state_d      = MEM_WAIT;
      wait_d       = state_q == RUN ? WW'(1) : wait_q == WW'(MAX_WAIT) ? wait_q : wait_q + 1'b1;
      timeout_d    = timeout_q | (wait_d == WW'(MAX_WAIT));
    end else if (rst) begin
      flush_if_id  = branch_taken;
      bubble_id_ex = branch_taken | hazard;
      freeze_pc    = !branch_taken && hazard;
      freeze_if_id = !branch_taken && hazard;
      state_d      = RUN;
      wait_d       = '0;
    end
  end
  // Control state, wait counter and sticky timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end
  assign mem_timeout = timeout_q;
`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic             stall_any;
  assign stall_any = freeze_pc | freeze_if_id | bubble_id_ex | flush_if_id | freeze_back;
  // Saturating count of cycles with any stall, bubble or flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else if (stall_any && stall_q != '1) stall_q <= stall_q + 1'b1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: scoreboard bench for pipeline_stall_controller
module tb_pipeline_stall_controller;
  localparam int MW = 5;
  localparam int CW = 4;
  typedef struct packed {
    logic [5:0]    c;
    logic [CW-1:0] s;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic hazard = 1'b0, branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id, freeze_back, mem_timeout;
  logic [CW-1:0] stall_cnt;
  logic [5:0]    obs;
  logic [CW-1:0] sc = '0;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  pipeline_stall_controller #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .freeze_pc(freeze_pc),
    .freeze_if_id(freeze_if_id), .bubble_id_ex(bubble_id_ex),
    .flush_if_id(flush_if_id), .freeze_back(freeze_back),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  assign obs = {freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id, freeze_back, mem_timeout};
  task automatic drive(input logic h, input logic b, input logic mq, input logic mr, input logic [5:0] c);
    @(negedge clk);
    hazard = h;
    branch_taken = b;
    mem_req = mq;
    mem_ready = mr;
    sb.push_back('{c, sc});
`ifdef STALL_PERF_CNT_EN
    if (|c[5:1] && sc != '1) sc = sc + 1'b1;
`endif
    #2;
  endtask
  task automatic test_reset();
    exp_t e;
    #2;
    checks++;
    if ({obs, stall_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got %b/%0d exp 000000/0", obs, stall_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 6'b000000);
      e = sb.pop_front();
      checks++;
      if ({obs, stall_cnt} !== {e.c, e.s}) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got %b/%0d exp %b/%0d", i, obs, stall_cnt, e.c, e.s);
      end
    end
  endtask
  task automatic test_hazard();
    logic [9:0] t [3] = '{10'b1000_111000, 10'b1000_111000, 10'b0000_000000};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive(t[i][9], t[i][8], t[i][7], t[i][6], t[i][5:0]);
      e = sb.pop_front();
      checks++;
      if ({obs, stall_cnt} !== {e.c, e.s}) begin
        errors++;
        $display("FAIL hazard[%0d]: got %b/%0d exp %b/%0d", i, obs, stall_cnt, e.c, e.s);
      end
    end
  endtask
  task automatic test_branch();
    logic [9:0] t [4] = '{10'b1100_001100, 10'b0100_001100, 10'b1000_111000, 10'b0000_000000};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive(t[i][9], t[i][8], t[i][7], t[i][6], t[i][5:0]);
      e = sb.pop_front();
      checks++;
      if ({obs, stall_cnt} !== {e.c, e.s}) begin
        errors++;
        $display("FAIL branch[%0d]: got %b/%0d exp %b/%0d", i, obs, stall_cnt, e.c, e.s);
      end
    end
  endtask
  task automatic test_mem_wait();
    logic [9:0] t [9] = '{10'b1110_110010, 10'b1110_110010, 10'b1110_110010, 10'b0000_110010,
                          10'b1011_111000, 10'b0000_000000, 10'b0111_001100, 10'b1000_111000,
                          10'b0000_000000};
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      drive(t[i][9], t[i][8], t[i][7], t[i][6], t[i][5:0]);
      e = sb.pop_front();
      checks++;
      if ({obs, stall_cnt} !== {e.c, e.s}) begin
        errors++;
        $display("FAIL mem_wait[%0d]: got %b/%0d exp %b/%0d", i, obs, stall_cnt, e.c, e.s);
      end
    end
  endtask
  task automatic test_timeout();
    logic [9:0] t [3] = '{10'b0011_000001, 10'b1000_111001, 10'b0000_000001};
    exp_t e;
    for (int k = 1; k <= MW + 2; k++) begin
      drive(0, 0, 1, 0, {5'b11001, k - 1 >= MW});
      e = sb.pop_front();
      checks++;
      if ({obs, stall_cnt} !== {e.c, e.s}) begin
        errors++;
        $display("FAIL timeout_wait[%0d]: got %b/%0d exp %b/%0d", k, obs, stall_cnt, e.c, e.s);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(t[i][9], t[i][8], t[i][7], t[i][6], t[i][5:0]);
      e = sb.pop_front();
      checks++;
      if ({obs, stall_cnt} !== {e.c, e.s}) begin
        errors++;
        $display("FAIL timeout_sticky[%0d]: got %b/%0d exp %b/%0d", i, obs, stall_cnt, e.c, e.s);
      end
    end
  endtask
  task automatic test_async_reset();
    logic [9:0] t [3] = '{10'b0000_000000, 10'b1000_111000, 10'b0000_000000};
    exp_t e;
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 1, 0, 6'b110011);
      e = sb.pop_front();
      checks++;
      if ({obs, stall_cnt} !== {e.c, e.s}) begin
        errors++;
        $display("FAIL pre_reset_wait[%0d]: got %b/%0d exp %b/%0d", k, obs, stall_cnt, e.c, e.s);
      end
    end
    #1 rst = 1'b0;
    sc = '0;
    #1;
    checks++;
    if ({obs, stall_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset_now: got %b/%0d exp 000000/0", obs, stall_cnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({obs, stall_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset_held: got %b/%0d exp 000000/0", obs, stall_cnt);
    end
    @(negedge clk);
    mem_req = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(t[i][9], t[i][8], t[i][7], t[i][6], t[i][5:0]);
      e = sb.pop_front();
      checks++;
      if ({obs, stall_cnt} !== {e.c, e.s}) begin
        errors++;
        $display("FAIL post_reset[%0d]: got %b/%0d exp %b/%0d", i, obs, stall_cnt, e.c, e.s);
      end
    end
  endtask
  initial begin
    test_reset();
    test_hazard();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
